// File: rtl/div_arbiter_pkg.sv
// rtl/div_arbiter_pkg.sv - shared types and constants for the divider arbiter
// Tag layout, id width helper and the divide-by-zero quotient pattern.
package div_arb_pkg;

   localparam int DEF_XLEN = 16;
   localparam int DEF_NREQ = 4;

   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int ID_W = id_width(DEF_NREQ);

   typedef struct packed {
      logic [ID_W-1:0]     id;
      logic                dz;
      logic [DEF_XLEN-1:0] a;
   } tag_t;

   // Sliced down to XLEN by users; wide enough for any practical operand width.
   localparam logic [63:0] QUO_ONES = '1;

endpackage

// File: rtl/div_arbiter_if.sv
// rtl/div_arbiter_if.sv - request, divider and response signals of div_arbiter
// master = requesters plus divider, slave = the arbiter.
interface div_arbiter_if import div_arb_pkg::*; #(
   parameter int XLEN = DEF_XLEN,
   parameter int NREQ = DEF_NREQ
) ();
   logic [NREQ-1:0]      req_valid;
   logic [NREQ-1:0]      req_ready;
   logic [NREQ*XLEN-1:0] req_a;
   logic [NREQ*XLEN-1:0] req_b;
   logic [XLEN-1:0]      div_a;
   logic [XLEN-1:0]      div_b;
   logic                 div_vld;
   logic [XLEN-1:0]      div_quo;
   logic [XLEN-1:0]      div_rem;
   logic                 div_ack;
   logic [NREQ-1:0]      rsp_valid;
   logic [XLEN-1:0]      rsp_quo;
   logic [XLEN-1:0]      rsp_rem;
   logic                 rsp_dz;
   logic                 err;

   modport master (
      output req_valid, req_a, req_b, div_quo, div_rem, div_ack,
      input  req_ready, div_a, div_b, div_vld, rsp_valid, rsp_quo, rsp_rem, rsp_dz, err
   );

   modport slave (
      input  req_valid, req_a, req_b, div_quo, div_rem, div_ack,
      output req_ready, div_a, div_b, div_vld, rsp_valid, rsp_quo, rsp_rem, rsp_dz, err
   );
endinterface

// File: rtl/div_arbiter_tag_fifo.sv
// rtl/div_arbiter_tag_fifo.sv - show-ahead in-order tag FIFO
// Head entry is visible on dout_o while not empty; push when full and pop when empty are ignored.
module div_tag_fifo #(
   parameter int  DEPTH   = 32,
   parameter type entry_t = div_arb_pkg::tag_t,
   localparam int CW      = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push_i,
   input  entry_t        din_i,
   input  logic          pop_i,
   output entry_t        dout_o,
   output logic          full_o,
   output logic          empty_o,
   output logic [CW-1:0] count_o
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   entry_t          mem_q [DEPTH];
   logic [PW-1:0]   wr_ptr_q;
   logic [PW-1:0]   rd_ptr_q;
   logic [CW-1:0]   count_q;
   logic            do_push;
   logic            do_pop;

   function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign dout_o  = mem_q[rd_ptr_q];
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
            wr_ptr_q        <= bump(wr_ptr_q);
         end
         if (do_pop) begin
            rd_ptr_q <= bump(rd_ptr_q);
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end
endmodule

// File: rtl/divfunc.sv
// rtl/divfunc.sv - two-stage pipelined unsigned divider shared by the arbiter
// Accepts one operand pair per cycle; ack_o follows vld_i by two cycles. b == 0 returns zeros.
module divfunc #(
   parameter int XLEN = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            vld_i,
   input  logic [XLEN-1:0] a_i,
   input  logic [XLEN-1:0] b_i,
   output logic [XLEN-1:0] quo_o,
   output logic [XLEN-1:0] rem_o,
   output logic            ack_o
);
   logic            v1_q;
   logic [XLEN-1:0] a1_q;
   logic [XLEN-1:0] b1_q;
   logic            ack_q;
   logic [XLEN-1:0] quo_q;
   logic [XLEN-1:0] rem_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         v1_q  <= 1'b0;
         ack_q <= 1'b0;
         a1_q  <= '0;
         b1_q  <= '0;
         quo_q <= '0;
         rem_q <= '0;
      end else begin
         v1_q  <= vld_i;
         a1_q  <= a_i;
         b1_q  <= b_i;
         ack_q <= v1_q;
         if (b1_q == '0) begin
            quo_q <= '0;
            rem_q <= '0;
         end else begin
            quo_q <= a1_q / b1_q;
            rem_q <= a1_q % b1_q;
         end
      end
   end

   assign quo_o = quo_q;
   assign rem_o = rem_q;
   assign ack_o = ack_q;
endmodule

// File: rtl/div_arbiter.sv
// rtl/div_arbiter.sv - round-robin arbiter sharing one in-order divider among NREQ requesters
// Grants are issued registered, tagged in a FIFO, and responses are routed back by tag on div_ack.
module div_arbiter import div_arb_pkg::*; #(
   parameter int XLEN    = DEF_XLEN,
   parameter int NREQ    = DEF_NREQ,
   parameter int MAX_OUT = 32
) (
   input  logic            clk,
   input  logic            rst,
   div_arbiter_if.slave    bus
);
   localparam int IDW = id_width(NREQ);
   localparam int CW  = $clog2(MAX_OUT + 1);

   typedef struct packed {
      logic [IDW-1:0]  id;
      logic            dz;
      logic [XLEN-1:0] a;
   } slot_t;

   logic [IDW-1:0]  last_grant_q;
   logic [XLEN-1:0] div_a_q, div_b_q;
   logic            div_vld_q;
   logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
   logic [XLEN-1:0] rsp_quo_q, rsp_quo_d;
   logic [XLEN-1:0] rsp_rem_q, rsp_rem_d;
   logic            rsp_dz_q, rsp_dz_d;
   logic            err_q;

   logic [NREQ-1:0] grant;
   logic [IDW-1:0]  grant_id;
   logic [XLEN-1:0] sel_a, sel_b;
   logic            stall, accept, pop;
   slot_t           push_tag, head;
   logic            fifo_full, fifo_empty;
   logic [CW-1:0]   fifo_count;

   // Rotating priority: the search starts just past the last granted requester.
   always_comb begin
      int  idx;
      logic found;
      idx      = 0;
      found    = 1'b0;
      grant    = '0;
      grant_id = '0;
      for (int k = 1; k <= NREQ; k++) begin
         idx = (int'(last_grant_q) + k) % NREQ;
         if (!found && bus.req_valid[idx]) begin
            found       = 1'b1;
            grant[idx]  = 1'b1;
            grant_id    = IDW'(idx);
         end
      end
   end

   assign stall         = (fifo_count == CW'(MAX_OUT));
   assign bus.req_ready = (stall || rst) ? '0 : grant;
   assign accept        = |bus.req_ready & ~fifo_full;
   assign sel_a         = bus.req_a[grant_id*XLEN +: XLEN];
   assign sel_b         = bus.req_b[grant_id*XLEN +: XLEN];
   assign push_tag      = '{id: grant_id, dz: (sel_b == '0), a: sel_a};
   assign pop           = bus.div_ack & ~fifo_empty;

   div_tag_fifo #(
      .DEPTH   (MAX_OUT),
      .entry_t (slot_t)
   ) u_tag_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (accept),
      .din_i   (push_tag),
      .pop_i   (pop),
      .dout_o  (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   // Divide-by-zero results are replaced here; the divider output is ignored for those tags.
   always_comb begin
      rsp_valid_d = '0;
      for (int i = 0; i < NREQ; i++) begin
         rsp_valid_d[i] = pop && (head.id == IDW'(i));
      end
      rsp_dz_d  = pop ? head.dz : rsp_dz_q;
      rsp_quo_d = rsp_quo_q;
      rsp_rem_d = rsp_rem_q;
      if (pop) begin
         rsp_quo_d = head.dz ? QUO_ONES[XLEN-1:0] : bus.div_quo;
         rsp_rem_d = head.dz ? head.a : bus.div_rem;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant_q <= IDW'(NREQ - 1);
         div_a_q      <= '0;
         div_b_q      <= '0;
         div_vld_q    <= 1'b0;
         rsp_valid_q  <= '0;
         rsp_quo_q    <= '0;
         rsp_rem_q    <= '0;
         rsp_dz_q     <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         div_vld_q   <= accept;
         if (accept) begin
            div_a_q      <= sel_a;
            div_b_q      <= sel_b;
            last_grant_q <= grant_id;
         end
         rsp_valid_q <= rsp_valid_d;
         rsp_quo_q   <= rsp_quo_d;
         rsp_rem_q   <= rsp_rem_d;
         rsp_dz_q    <= rsp_dz_d;
         if (bus.div_ack && fifo_empty) begin
            err_q <= 1'b1;
         end
      end
   end

   assign bus.div_a     = div_a_q;
   assign bus.div_b     = div_b_q;
   assign bus.div_vld   = div_vld_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_quo   = rsp_quo_q;
   assign bus.rsp_rem   = rsp_rem_q;
   assign bus.rsp_dz    = rsp_dz_q;
   assign bus.err       = err_q;
endmodule

// File: tb/tb_div_arbiter.sv
// tb/tb_div_arbiter.sv - directed self-checking bench for div_arbiter
// dut0 uses divfunc as its divider; dut1 (MAX_OUT=2) has its divider results driven by the bench.
module tb_div_arbiter;
   logic clk;
   logic rst;
   logic div_rst;
   int   n_cmp;
   int   n_bad;

   div_arbiter_if #(.XLEN(16), .NREQ(4)) b0 ();
   div_arbiter_if #(.XLEN(16), .NREQ(4)) b1 ();

   div_arbiter #(.XLEN(16), .NREQ(4), .MAX_OUT(32)) u_dut0 (.clk(clk), .rst(rst), .bus(b0));
   div_arbiter #(.XLEN(16), .NREQ(4), .MAX_OUT(2))  u_dut1 (.clk(clk), .rst(rst), .bus(b1));

   divfunc #(.XLEN(16)) u_div (
      .clk(clk), .rst(div_rst), .vld_i(b0.div_vld), .a_i(b0.div_a), .b_i(b0.div_b),
      .quo_o(b0.div_quo), .rem_o(b0.div_rem), .ack_o(b0.div_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op0(input int i, input logic [15:0] a, input logic [15:0] b);
      b0.req_a[i*16 +: 16] = a;
      b0.req_b[i*16 +: 16] = b;
   endtask

   task automatic test_reset();
      rst = 1'b1; div_rst = 1'b1;
      b0.req_valid = 4'hF; b0.req_a = '0; b0.req_b = '0;
      b1.req_valid = 4'hF; b1.req_a = '0; b1.req_b = '0;
      b1.div_ack = 1'b0; b1.div_quo = '0; b1.div_rem = '0;
      tick(); tick();
      n_cmp++; if (b0.req_ready !== 4'h0) begin n_bad++; $display("FAIL rst_ready0 got=%b want=0000", b0.req_ready); end
      n_cmp++; if (b1.req_ready !== 4'h0) begin n_bad++; $display("FAIL rst_ready1 got=%b want=0000", b1.req_ready); end
      n_cmp++; if ({b0.div_vld, b0.rsp_valid, b0.rsp_dz, b0.err} !== 7'h0) begin n_bad++; $display("FAIL rst_flags0 got=%b want=0000000", {b0.div_vld, b0.rsp_valid, b0.rsp_dz, b0.err}); end
      n_cmp++; if ({b0.div_a, b0.div_b, b0.rsp_quo, b0.rsp_rem} !== 64'h0) begin n_bad++; $display("FAIL rst_data0 got=%h want=0", {b0.div_a, b0.div_b, b0.rsp_quo, b0.rsp_rem}); end
      n_cmp++; if ({b1.div_vld, b1.rsp_valid, b1.rsp_dz, b1.err} !== 7'h0) begin n_bad++; $display("FAIL rst_flags1 got=%b want=0000000", {b1.div_vld, b1.rsp_valid, b1.rsp_dz, b1.err}); end
      b0.req_valid = 4'h0; b1.req_valid = 4'h0;
      rst = 1'b0; div_rst = 1'b0;
      tick();
      b0.req_valid = 4'b1010;
      #1;
      n_cmp++; if (b0.req_ready !== 4'b0010) begin n_bad++; $display("FAIL rst_priority got=%b want=0010", b0.req_ready); end
      b0.req_valid = 4'b0000;
      #1;
   endtask

   task automatic test_single();
      set_op0(0, 16'd10000, 16'd500);
      b0.req_valid = 4'b0001;
      #1;
      n_cmp++; if (b0.req_ready !== 4'b0001) begin n_bad++; $display("FAIL single_ready got=%b want=0001", b0.req_ready); end
      tick();
      b0.req_valid = 4'b0000;
      n_cmp++; if ({b0.div_vld, b0.div_a, b0.div_b} !== {1'b1, 16'd10000, 16'd500}) begin n_bad++; $display("FAIL single_issue got=%h want=%h", {b0.div_vld, b0.div_a, b0.div_b}, {1'b1, 16'd10000, 16'd500}); end
      tick(); tick();
      n_cmp++; if (b0.rsp_valid !== 4'b0000) begin n_bad++; $display("FAIL single_early got=%b want=0000", b0.rsp_valid); end
      tick();
      n_cmp++; if ({b0.rsp_valid, b0.rsp_quo, b0.rsp_rem, b0.rsp_dz} !== {4'b0001, 16'd20, 16'd0, 1'b0}) begin n_bad++; $display("FAIL single_rsp got=%h want=%h", {b0.rsp_valid, b0.rsp_quo, b0.rsp_rem, b0.rsp_dz}, {4'b0001, 16'd20, 16'd0, 1'b0}); end
      tick();
      n_cmp++; if (b0.rsp_valid !== 4'b0000) begin n_bad++; $display("FAIL single_pulse got=%b want=0000", b0.rsp_valid); end
   endtask

   task automatic test_round_robin();
      logic [3:0] exp_v;
      rst = 1'b1; tick(); rst = 1'b0;
      for (int i = 0; i < 4; i++) set_op0(i, 16'd45000, 16'd7);
      for (int k = 0; k < 12; k++) begin
         b0.req_valid = (k < 8) ? 4'hF : 4'h0;
         #1;
         if (k < 8) begin
            exp_v = 4'(1 << (k % 4));
            n_cmp++; if (b0.req_ready !== exp_v) begin n_bad++; $display("FAIL rr_grant k=%0d got=%b want=%b", k, b0.req_ready, exp_v); end
         end
         if (k >= 4) begin
            exp_v = 4'(1 << ((k - 4) % 4));
            n_cmp++; if ({b0.rsp_valid, b0.rsp_quo, b0.rsp_rem, b0.rsp_dz} !== {exp_v, 16'd6428, 16'd4, 1'b0}) begin n_bad++; $display("FAIL rr_rsp k=%0d got=%h want=%h", k, {b0.rsp_valid, b0.rsp_quo, b0.rsp_rem, b0.rsp_dz}, {exp_v, 16'd6428, 16'd4, 1'b0}); end
         end
         tick();
      end
      n_cmp++; if (b0.rsp_valid !== 4'b0000) begin n_bad++; $display("FAIL rr_idle got=%b want=0000", b0.rsp_valid); end
   endtask

   task automatic test_div_by_zero();
      logic [3:0]  v_tab [7] = '{4'b0010, 4'b0100, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
      logic [32:0] iss_tab [3] = '{{1'b1, 16'd100, 16'd7}, {1'b1, 16'd123, 16'd0}, {1'b1, 16'd50, 16'd5}};
      logic [36:0] rsp_tab [3] = '{{4'b0010, 16'd14, 16'd2, 1'b0}, {4'b0100, 16'hFFFF, 16'd123, 1'b1}, {4'b1000, 16'd10, 16'd0, 1'b0}};
      set_op0(1, 16'd100, 16'd7);
      set_op0(2, 16'd123, 16'd0);
      set_op0(3, 16'd50, 16'd5);
      for (int k = 0; k < 7; k++) begin
         b0.req_valid = v_tab[k];
         #1;
         if (k < 3) begin
            n_cmp++; if (b0.req_ready !== v_tab[k]) begin n_bad++; $display("FAIL dz_grant k=%0d got=%b want=%b", k, b0.req_ready, v_tab[k]); end
         end
         if (k >= 1 && k <= 3) begin
            n_cmp++; if ({b0.div_vld, b0.div_a, b0.div_b} !== iss_tab[k-1]) begin n_bad++; $display("FAIL dz_issue k=%0d got=%h want=%h", k, {b0.div_vld, b0.div_a, b0.div_b}, iss_tab[k-1]); end
         end
         if (k >= 4) begin
            n_cmp++; if ({b0.rsp_valid, b0.rsp_quo, b0.rsp_rem, b0.rsp_dz} !== rsp_tab[k-4]) begin n_bad++; $display("FAIL dz_rsp k=%0d got=%h want=%h", k, {b0.rsp_valid, b0.rsp_quo, b0.rsp_rem, b0.rsp_dz}, rsp_tab[k-4]); end
         end
         tick();
      end
      b0.req_valid = 4'h0;
   endtask

   task automatic test_stall();
      logic       ack_tab [12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      logic [3:0] rdy_tab [12] = '{4'd1, 4'd1, 4'd0, 4'd0, 4'd1, 4'd0, 4'd1, 4'd1, 4'd0, 4'd1, 4'd1, 4'd0};
      logic [3:0] exp_v;
      b1.req_a[15:0] = 16'd20;
      b1.req_b[15:0] = 16'd3;
      for (int k = 0; k < 13; k++) begin
         b1.req_valid = (k <= 10) ? 4'b0001 : 4'b0000;
         b1.div_ack   = (k <= 11) ? ack_tab[k] : 1'b0;
         b1.div_quo   = 16'(k + 100);
         b1.div_rem   = 16'(k);
         #1;
         if (k <= 11) begin
            n_cmp++; if (b1.req_ready !== rdy_tab[k]) begin n_bad++; $display("FAIL stall_ready k=%0d got=%b want=%b", k, b1.req_ready, rdy_tab[k]); end
         end
         exp_v = (k > 0 && ack_tab[k-1]) ? 4'b0001 : 4'b0000;
         n_cmp++; if (b1.rsp_valid !== exp_v) begin n_bad++; $display("FAIL stall_rsp k=%0d got=%b want=%b", k, b1.rsp_valid, exp_v); end
         if (exp_v != 4'b0000) begin
            n_cmp++; if ({b1.rsp_quo, b1.rsp_rem} !== {16'(k + 99), 16'(k - 1)}) begin n_bad++; $display("FAIL stall_data k=%0d got=%h want=%h", k, {b1.rsp_quo, b1.rsp_rem}, {16'(k + 99), 16'(k - 1)}); end
         end
         tick();
      end
      n_cmp++; if (b1.err !== 1'b0) begin n_bad++; $display("FAIL stall_err got=%b want=0", b1.err); end
   endtask

   task automatic test_spurious();
      logic [3:0] rdy_tab [3] = '{4'b0001, 4'b0001, 4'b0000};
      b1.div_ack = 1'b1;
      tick();
      b1.div_ack = 1'b0;
      n_cmp++; if ({b1.err, b1.rsp_valid} !== 5'b1_0000) begin n_bad++; $display("FAIL spur_err got=%b want=10000", {b1.err, b1.rsp_valid}); end
      tick(); tick();
      n_cmp++; if ({b1.err, b1.rsp_valid} !== 5'b1_0000) begin n_bad++; $display("FAIL spur_sticky got=%b want=10000", {b1.err, b1.rsp_valid}); end
      for (int k = 0; k < 3; k++) begin
         b1.req_valid = 4'b0001;
         #1;
         n_cmp++; if (b1.req_ready !== rdy_tab[k]) begin n_bad++; $display("FAIL spur_count k=%0d got=%b want=%b", k, b1.req_ready, rdy_tab[k]); end
         tick();
      end
      b1.req_valid = 4'b0000;
   endtask

   task automatic test_reset_in_flight();
      rst = 1'b1; tick(); rst = 1'b0;
      set_op0(0, 16'd1000, 16'd10);
      set_op0(1, 16'd999, 16'd9);
      set_op0(2, 16'd77, 16'd7);
      for (int k = 0; k < 3; k++) begin
         b0.req_valid = 4'b0111;
         #1;
         n_cmp++; if (b0.req_ready !== 4'(1 << k)) begin n_bad++; $display("FAIL rif_grant k=%0d got=%b want=%b", k, b0.req_ready, 4'(1 << k)); end
         tick();
      end
      rst = 1'b1;
      #1;
      n_cmp++; if (b0.req_ready !== 4'b0000) begin n_bad++; $display("FAIL rif_ready_in_rst got=%b want=0000", b0.req_ready); end
      tick();
      rst = 1'b0;
      b0.req_valid = 4'b0000;
      n_cmp++; if ({b0.div_vld, b0.rsp_valid, b0.rsp_dz, b0.err} !== 7'h0) begin n_bad++; $display("FAIL rif_flags got=%b want=0000000", {b0.div_vld, b0.rsp_valid, b0.rsp_dz, b0.err}); end
      n_cmp++; if ({b0.div_a, b0.div_b, b0.rsp_quo, b0.rsp_rem} !== 64'h0) begin n_bad++; $display("FAIL rif_data got=%h want=0", {b0.div_a, b0.div_b, b0.rsp_quo, b0.rsp_rem}); end
      tick();
      n_cmp++; if ({b0.err, b0.rsp_valid} !== 5'b1_0000) begin n_bad++; $display("FAIL rif_stale_err got=%b want=10000", {b0.err, b0.rsp_valid}); end
      tick();
      n_cmp++; if ({b0.err, b0.rsp_valid} !== 5'b1_0000) begin n_bad++; $display("FAIL rif_stale_drop got=%b want=10000", {b0.err, b0.rsp_valid}); end
      tick();
      n_cmp++; if ({b0.err, b0.rsp_valid} !== 5'b1_0000) begin n_bad++; $display("FAIL rif_quiet got=%b want=10000", {b0.err, b0.rsp_valid}); end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      test_reset();
      test_single();
      test_round_robin();
      test_div_by_zero();
      test_stall();
      test_spurious();
      test_reset_in_flight();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/div_arbiter.md
DIV_ARBITER -- requirements
Module: div_arbiter

Interface
REQ-001 Parameter XLEN, default 16, operand/result width in bits.
REQ-002 Parameter NREQ, default 4, number of requesters (2..8).
REQ-003 Parameter MAX_OUT, default 32, maximum divisions in flight; SHALL be >= divfunc pipeline depth.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 req_valid  in  NREQ  per-requester request strobe.
REQ-007 req_ready  out  NREQ  per-requester accept; transfer when valid&ready.
REQ-008 req_a  in  NREQ*XLEN  dividends, requester i at bits [i*XLEN +: XLEN].
REQ-009 req_b  in  NREQ*XLEN  divisors, same packing.
REQ-010 div_a / div_b  out  XLEN each  operands to shared divfunc.
REQ-011 div_vld  out  1  issue strobe to divfunc.
REQ-012 div_quo / div_rem  in  XLEN each  divfunc results.
REQ-013 div_ack  in  1  divfunc result strobe; results return in issue order.
REQ-014 rsp_valid  out  NREQ  one-hot response strobe, one cycle.
REQ-015 rsp_quo / rsp_rem  out  XLEN each  shared response bus, valid with rsp_valid.
REQ-016 rsp_dz  out  1  divide-by-zero flag, valid with rsp_valid.
REQ-017 err  out  1  sticky protocol error.

Function
REQ-018 At most one grant per cycle; req_ready SHALL be one-hot or zero.
REQ-019 Arbitration SHALL be round-robin: search starts at requester (last_grant+1) mod NREQ; after reset last_grant = NREQ-1, so requester 0 has priority.
REQ-020 req_ready[i] SHALL depend combinationally on req_valid and internal state only, never on div_ack of the same cycle.
REQ-021 On a grant, div_a/div_b/div_vld SHALL be registered: issue appears one cycle after the accepting edge.
REQ-022 Per grant, a tag {requester id, dz bit} SHALL be pushed into an in-order tag FIFO of depth MAX_OUT.
REQ-023 Grants SHALL stall (all req_ready = 0) when the outstanding count equals MAX_OUT.
REQ-024 Outstanding count: +1 on grant, -1 on div_ack, unchanged when both occur in the same cycle.
REQ-025 On div_ack, pop one tag; register rsp_valid[id], rsp_quo, rsp_rem, rsp_dz one cycle later.
REQ-026 Divide by zero (b == 0): operands still issued to keep order; response SHALL override to quo = all ones, rem = a (a held in FIFO entry), rsp_dz = 1.
REQ-027 Unsigned arithmetic only; no width growth; rsp_quo/rsp_rem are exactly XLEN bits.
REQ-028 div_ack with empty tag FIFO SHALL set err, produce no rsp_valid, and leave the count at 0 (no underflow).
REQ-029 Accepted-request-to-rsp_valid latency SHALL be divfunc latency + 2 cycles.
REQ-030 A requester holding req_valid high SHALL be granted within NREQ cycles while not stalled.

Reset
REQ-031 With rst high: req_ready = 0, div_vld = 0, rsp_valid = 0, rsp_dz = 0, err = 0, div_a/div_b/rsp_quo/rsp_rem = 0, count = 0, FIFO empty, last_grant = NREQ-1.
REQ-032 Reset mid-operation SHALL discard in-flight tags; div_ack arriving in the first cycles after reset release for pre-reset work SHALL set err and be dropped.

Structure
REQ-033 Package div_arb_pkg SHALL hold ID width ($clog2(NREQ)), tag struct {id, dz, a}, and all-ones quotient constant.
REQ-034 Tag FIFO SHALL be sub-module div_tag_fifo (synchronous, show-ahead, full/empty/count outputs).
REQ-035 Bench SHALL use divfunc (XLEN = 16) as the shared divider.

Verification
REQ-036 Single: req 0 a=10000 b=500 -> rsp_valid = 0001, quo=20, rem=0, dz=0.
REQ-037 All four valid constantly, b=7 a=45000 -> grant order 0,1,2,3,0...; each rsp quo=6428 rem=4.
REQ-038 Req 2 a=123 b=0 -> rsp_valid = 0100, quo=FFFF, rem=123, dz=1; neighbouring responses unaffected.
REQ-039 MAX_OUT=2 with divider ack delayed -> req_ready low after 2 grants, resumes on first ack; simultaneous grant+ack keeps count = 2.
REQ-040 Spurious div_ack with no outstanding work -> err = 1 and stays 1; rsp_valid stays 0.
REQ-041 rst asserted with 3 in flight -> all outputs at reset values next cycle; later stale acks set err, no rsp_valid.
